sa_tile_seq: RTL and testbench

Tile sequencer for the ROWS×COLS INT8 systolic array built from `pe_int8_dsp` cells. For each tile it clears the accumulators, drives the wavefront valid strobes on the array's west (A) and north (B) edges, steps the global shift enable through feed and flush, and pulses done when every PE holds its final INT32 sum. It sits between the operand feeders and the array; it carries no operand data itself.

---
 rtl/sa_tile_seq.sv | 109 ++++++++++
 tb/tb_sa_tile_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sa_tile_seq.sv
// rtl/sa_tile_seq.sv - tile sequencer driving clear, wavefront valids and shift enable for a systolic array
module sa_tile_seq #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_BITS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [K_BITS-1:0] k_len_i,
    input  logic              feed_vld_i,
    output logic              busy_o,
    output logic              clr_o,
    output logic              shift_en_o,
    output logic              feed_pop_o,
    output logic [ROWS-1:0]   a_v_o,
    output logic [COLS-1:0]   b_v_o,
    output logic              done_o,
    output logic              underrun_o
);

    localparam int M_MAX = (ROWS > COLS) ? ROWS : COLS;
    localparam int M_MIN = (ROWS < COLS) ? ROWS : COLS;
    localparam int TW    = K_BITS + 1;
    localparam bit SKIP_FLUSH = (M_MIN == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_PRIME,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [K_BITS-1:0] k_q;
    logic [TW-1:0]     t_q;
    logic              underrun_q;

    // One extra bit so K+r and K+ROWS+COLS-3 never wrap in comparisons.
    logic [TW:0] t_ext, k_ext, feed_last, flush_last;
    assign t_ext      = {1'b0, t_q};
    assign k_ext      = {2'b00, k_q};
    assign feed_last  = k_ext + (TW+1)'(M_MAX - 2);
    assign flush_last = k_ext + (TW+1)'(ROWS + COLS - 3);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            k_q        <= '0;
            t_q        <= '0;
            underrun_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start_i) k_q <= k_len_i;
                end
                S_CLEAR: begin
                    t_q        <= '0;
                    underrun_q <= 1'b0;
                end
                S_FEED: begin
                    t_q <= t_q + 1'b1;
                    if (!feed_vld_i) underrun_q <= 1'b1;
                end
                S_FLUSH: begin
                    t_q <= t_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FEED never stalls: a held wavefront would re-accumulate in interior PEs.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (k_q == '0) ? S_DONE : S_PRIME;
            S_PRIME: if (feed_vld_i) state_nxt = S_FEED;
            S_FEED:  if (t_ext == feed_last) state_nxt = SKIP_FLUSH ? S_DONE : S_FLUSH;
            S_FLUSH: if (t_ext == flush_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state != S_IDLE);
        clr_o      = (state == S_CLEAR);
        shift_en_o = (state == S_FEED) || (state == S_FLUSH);
        feed_pop_o = (state == S_FEED);
        done_o     = (state == S_DONE);
        underrun_o = underrun_q;
        a_v_o      = '0;
        b_v_o      = '0;
        for (int r = 0; r < ROWS; r++) begin
            a_v_o[r] = (state == S_FEED) && (t_ext >= (TW+1)'(r)) &&
                       (t_ext < k_ext + (TW+1)'(r));
        end
        for (int c = 0; c < COLS; c++) begin
            b_v_o[c] = (state == S_FEED) && (t_ext >= (TW+1)'(c)) &&
                       (t_ext < k_ext + (TW+1)'(c));
        end
    end

endmodule

// File: tb/tb_sa_tile_seq.sv
// tb/tb_sa_tile_seq.sv - randomized self-checking bench for sa_tile_seq (4x4 and 2x5 instances)
module tb_sa_tile_seq;

    localparam int KB = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start0 = 1'b0, start1 = 1'b0;
    logic [KB-1:0] k_len = '0;
    logic          feed_vld = 1'b0;

    logic       busy0, clr0, sh0, pop0, done0, un0;
    logic [3:0] a0, b0;
    logic       busy1, clr1, sh1, pop1, done1, un1;
    logic [1:0] a1;
    logic [4:0] b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_u0 = 1'b0, exp_u1 = 1'b0;

    always #5 clk = ~clk;

    sa_tile_seq #(.ROWS(4), .COLS(4), .K_BITS(KB)) u_sq (
        .clk(clk), .rstn(rstn), .start_i(start0), .k_len_i(k_len),
        .feed_vld_i(feed_vld), .busy_o(busy0), .clr_o(clr0),
        .shift_en_o(sh0), .feed_pop_o(pop0), .a_v_o(a0), .b_v_o(b0),
        .done_o(done0), .underrun_o(un0)
    );

    sa_tile_seq #(.ROWS(2), .COLS(5), .K_BITS(KB)) u_rect (
        .clk(clk), .rstn(rstn), .start_i(start1), .k_len_i(k_len),
        .feed_vld_i(feed_vld), .busy_o(busy1), .clr_o(clr1),
        .shift_en_o(sh1), .feed_pop_o(pop1), .a_v_o(a1), .b_v_o(b1),
        .done_o(done1), .underrun_o(un1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int done_cycle(int r_n, int c_n, int k, int f0);
        return (k == 0) ? 2 : f0 + k + r_n + c_n - 2;
    endfunction

    function automatic bit in_feed(int r_n, int c_n, int k, int f0, int c);
        int mx = (r_n > c_n) ? r_n : c_n;
        return (k != 0) && (c >= f0) && (c <= f0 + k + mx - 2);
    endfunction

    // Expected {busy,clr,shift,pop,done,a[7:0],b[7:0]} at cycle c of a tile started at cycle 0.
    function automatic logic [31:0] model(int r_n, int c_n, int k, int f0, int c);
        int d = done_cycle(r_n, c_n, k, f0);
        bit feed = in_feed(r_n, c_n, k, f0, c);
        bit flush = (k != 0) && (c >= f0) && !feed && (c < d);
        int t = c - f0;
        logic [7:0] av = '0, bv = '0;
        for (int r = 0; r < r_n; r++) av[r] = feed && (t >= r) && (t < k + r);
        for (int q = 0; q < c_n; q++) bv[q] = feed && (t >= q) && (t < k + q);
        return {11'b0, (c >= 1 && c <= d), (c == 1), (feed || flush), feed, (c == d), av, bv};
    endfunction

    function automatic logic [31:0] got0();
        return {11'b0, busy0, clr0, sh0, pop0, done0, 4'b0, a0, 4'b0, b0};
    endfunction

    function automatic logic [31:0] got1();
        return {11'b0, busy1, clr1, sh1, pop1, done1, 6'b0, a1, 3'b0, b1};
    endfunction

    task automatic run_tile(input int k, input int w, input int drop, input bit hold, input int abort);
        int f0 = (k == 0) ? 3 : 3 + w;
        int d0 = done_cycle(4, 4, k, f0);
        int d1 = done_cycle(2, 5, k, f0);
        int last = (d0 > d1) ? d0 : d1;
        for (int c = 0; c <= last; c++) begin
            k_len  = (c == 0) ? KB'(k) : KB'($urandom);
            start0 = (c == 0) || (hold && c <= d0);
            start1 = (c == 0) || (hold && c <= d1);
            if (k != 0 && c >= 2 && c < f0 - 1)  feed_vld = 1'b0;
            else if (k != 0 && c == f0 - 1)      feed_vld = 1'b1;
            else if (c >= f0)                    feed_vld = (c != drop);
            else                                 feed_vld = 1'($urandom);
            if (c == abort) rstn = 1'b0;
            @(negedge clk);
            if (c == abort) begin
                check("reset_out0", got0(), 32'h0);
                check("reset_out1", got1(), 32'h0);
                check("reset_un", {30'b0, un0, un1}, 32'h0);
                exp_u0 = 1'b0;
                exp_u1 = 1'b0;
                start0 = 1'b0;
                start1 = 1'b0;
                @(posedge clk); #1;
                rstn = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("post_abort0", got0(), 32'h0);
                    check("post_abort1", got1(), 32'h0);
                    @(posedge clk); #1;
                end
                return;
            end
            check($sformatf("sq k=%0d c=%0d", k, c), got0(), model(4, 4, k, f0, c));
            check($sformatf("rect k=%0d c=%0d", k, c), got1(), model(2, 5, k, f0, c));
            if (c != 1) begin
                check($sformatf("un_sq c=%0d", c), {31'b0, un0}, {31'b0, exp_u0});
                check($sformatf("un_rect c=%0d", c), {31'b0, un1}, {31'b0, exp_u1});
            end
            if (c == 1) begin
                exp_u0 = 1'b0;
                exp_u1 = 1'b0;
            end
            if (in_feed(4, 4, k, f0, c) && !feed_vld) exp_u0 = 1'b1;
            if (in_feed(2, 5, k, f0, c) && !feed_vld) exp_u1 = 1'b1;
            @(posedge clk); #1;
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("init_out0", got0(), 32'h0);
        check("init_out1", got1(), 32'h0);
        check("init_un", {30'b0, un0, un1}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        run_tile(8, 0, -1, 1'b0, -1);
        run_tile(0, 0, -1, 1'b0, -1);
        run_tile(5, 3, -1, 1'b0, -1);
        run_tile(5, 0, -1, 1'b0, -1);
        run_tile(6, 0, 7, 1'b0, -1);
        run_tile(3, 0, -1, 1'b0, -1);
        run_tile(3, 0, -1, 1'b1, -1);
        run_tile(1, 1, -1, 1'b1, -1);
        run_tile(6, 0, -1, 1'b0, 12);
        run_tile(6, 0, -1, 1'b0, -1);
        run_tile(300, 2, 150, 1'b0, -1);
        for (int i = 0; i < 25; i++) begin
            int k = $urandom_range(0, 20);
            int w = $urandom_range(0, 3);
            int drop = $urandom_range(0, 1) ? (3 + w + $urandom_range(0, k + 4)) : -1;
            run_tile(k, w, drop, 1'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
